// File: rtl/segment_weight_learner.sv
// Counts fed-back segment numbers and publishes them as four 8-bit chooser weights.
// Optional build macro WEIGHT_FLOOR_EN clamps every published weight to at least 1.
module segment_weight_learner #(
    parameter int unsigned MAX_SUM = 251
) (
    input  logic       in_clock,
    input  logic       in_reset,
    input  logic       in_valid,
    input  logic [1:0] in_segment_number,
    input  logic       in_clear,
    input  logic       in_publish,
    output logic       out_ready,
    output logic [7:0] out_weight0,
    output logic [7:0] out_weight1,
    output logic [7:0] out_weight2,
    output logic [7:0] out_weight3,
    output logic [7:0] out_sum_weights,
    output logic [7:0] out_total,
    output logic       out_publish_done
);

    typedef enum logic {ST_ACCUM, ST_DECAY} state_t;

    localparam logic [7:0] MAX_SUM_B = 8'(MAX_SUM);

    state_t     state_q, state_d;
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];
    logic [7:0] total_q, total_d;
    logic [1:0] pend_q, pend_d;
    logic [7:0] w_q [4];
    logic [7:0] w_d [4];
    logic [7:0] pw [4];
    logic [7:0] sum_q, sum_d;
    logic       done_q, done_d;
    logic       accept, pub_fire;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        total_d  = total_q;
        pend_d   = pend_q;
        w_d      = w_q;
        sum_d    = sum_q;
        accept   = in_valid && (state_q == ST_ACCUM);
        pub_fire = in_publish && !in_clear && (total_q != '0);

        // Publish samples the counters before this cycle's update; 8-bit sum is exact since total <= 251.
        for (int unsigned i = 0; i < 4; i++) begin
`ifdef WEIGHT_FLOOR_EN
            pw[i] = (cnt_q[i] == '0) ? 8'd1 : cnt_q[i];
`else
            pw[i] = cnt_q[i];
`endif
        end
        done_d = pub_fire;
        if (pub_fire) begin
            w_d   = pw;
            sum_d = pw[0] + pw[1] + pw[2] + pw[3];
        end

        if (in_clear) begin
            for (int unsigned i = 0; i < 4; i++) cnt_d[i] = '0;
            total_d = '0;
            state_d = ST_ACCUM;
        end else if (state_q == ST_DECAY) begin
            for (int unsigned i = 0; i < 4; i++)
                cnt_d[i] = (cnt_q[i] >> 1) + {7'd0, pend_q == 2'(i)};
            // Halved total is at most MAX_SUM/2 + 3, so 8-bit arithmetic loses nothing.
            total_d = cnt_d[0] + cnt_d[1] + cnt_d[2] + cnt_d[3];
            state_d = ST_ACCUM;
        end else if (accept) begin
            if (total_q < MAX_SUM_B) begin
                cnt_d[in_segment_number] = cnt_q[in_segment_number] + 8'd1;
                total_d = total_q + 8'd1;
            end else begin
                pend_d  = in_segment_number;
                state_d = ST_DECAY;
            end
        end
    end

    always_ff @(posedge in_clock) begin
        if (!in_reset) begin
            state_q <= ST_ACCUM;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
                w_q[i]   <= 8'd1;
            end
            total_q <= '0;
            pend_q  <= '0;
            sum_q   <= 8'd4;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            pend_q  <= pend_d;
            w_q     <= w_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
        end
    end

    assign out_ready        = (state_q == ST_ACCUM);
    assign out_weight0      = w_q[0];
    assign out_weight1      = w_q[1];
    assign out_weight2      = w_q[2];
    assign out_weight3      = w_q[3];
    assign out_sum_weights  = sum_q;
    assign out_total        = total_q;
    assign out_publish_done = done_q;

endmodule
